fetch_stage: RTL and testbench

Instruction-fetch stage ahead of the decode stage. Holds the fetch PC, reads instruction memory, and predicts the next PC with a direct-mapped branch target buffer (BTB) that uses 2-bit saturating counters. Packs `{hit, predBJ, pc, instr}` into the 66-bit decode buffer input. Trains the BTB from branch outcomes resolved in decode, and redirects the PC on a misprediction.

---
 rtl/fetch_stage_pkg.sv | 33 +++
 rtl/fetch_stage_btb.sv | 75 +++++++
 rtl/fetch_stage.sv | 78 +++++++
 tb/tb_fetch_stage.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared types, constants and counter helpers for the fetch stage
package fetch_stage_pkg;

  localparam int XLEN    = 32;
  localparam int BTB_IDX = 4;
  localparam int TAG_W   = XLEN - BTB_IDX - 2;
  localparam int BUFF_W  = 66;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    ctr_e             ctr;
  } btb_entry_t;

  // Saturating increment: stays at ST
  function automatic ctr_e ctr_inc(input ctr_e c);
    return (c == ST) ? ST : ctr_e'(c + 2'd1);
  endfunction

  // Saturating decrement: stays at SNT
  function automatic ctr_e ctr_dec(input ctr_e c);
    return (c == SNT) ? SNT : ctr_e'(c - 2'd1);
  endfunction

endpackage

// File: rtl/fetch_stage_btb.sv
// rtl/fetch_stage_btb.sv - direct-mapped branch target buffer with 2-bit counters
module fetch_stage_btb
  import fetch_stage_pkg::*;
#(
  parameter int btbIdx = BTB_IDX
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] lk_pc,
  output logic            lk_hit,
  output logic            lk_taken,
  output logic [XLEN-1:0] lk_target,
  input  logic            train_en,
  input  logic            inval_en,
  input  logic            tr_hit,
  input  logic            tr_taken,
  input  logic [XLEN-1:0] tr_pc,
  input  logic [XLEN-1:0] tr_target
);

  localparam int N = 2 ** btbIdx;

  btb_entry_t ent_q [N];
  btb_entry_t ent_d [N];
  btb_entry_t rd_ent;

  logic [btbIdx-1:0] li;
  logic [btbIdx-1:0] ti;
  logic [TAG_W-1:0]  lt;
  logic [TAG_W-1:0]  tt;

  assign li = lk_pc[btbIdx+1:2];
  assign lt = lk_pc[XLEN-1:btbIdx+2];
  assign ti = tr_pc[btbIdx+1:2];
  assign tt = tr_pc[XLEN-1:btbIdx+2];

  // Read port: sees pre-write contents during a same-cycle update
  always_comb begin
    rd_ent    = ent_q[li];
    lk_hit    = rd_ent.valid && (rd_ent.tag == lt);
    lk_taken  = lk_hit && rd_ent.ctr[1];
    lk_target = rd_ent.target;
  end

  // Write port: train on resolved branches, drop stale predictions
  always_comb begin
    ent_d = ent_q;
    if (train_en) begin
      if (tr_hit) begin
        if (tr_taken) begin
          ent_d[ti].ctr    = ctr_inc(ent_q[ti].ctr);
          ent_d[ti].target = tr_target;
        end else begin
          ent_d[ti].ctr = ctr_dec(ent_q[ti].ctr);
        end
      end else if (tr_taken) begin
        ent_d[ti] = '{valid: 1'b1, tag: tt, target: tr_target, ctr: WT};
      end
    end else if (inval_en) begin
      ent_d[ti].valid = 1'b0;
    end
  end

  // Entry storage; reset empties the table and sets counters weakly not-taken
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        ent_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
      end
    end else begin
      ent_q <= ent_d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - fetch PC register, next-PC prediction and redirect on mispredict
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int          width   = 32,
  parameter int          btbIdx  = 4,
  parameter logic [31:0] resetPC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_F,
  input  logic              stall_D,
  input  logic [width-1:0]  imemData_F,
  input  logic              isBJ_D,
  input  logic              realBJ_D,
  input  logic              predBJ_D,
  input  logic              hit_D,
  input  logic [width-1:0]  pc_D,
  input  logic [width-1:0]  targetPC_D,
  output logic [width-1:0]  imemAddr_F,
  output logic [width-1:0]  pc_F,
  output logic              mispredict_F,
  output logic [BUFF_W-1:0] buffIn_D
);

  logic [width-1:0] pc_q;
  logic [width-1:0] pc_d;
  logic [width-1:0] pred_next;
  logic [width-1:0] correct_next;
  logic [width-1:0] btb_target;
  logic             hit_F;
  logic             predBJ_F;
  logic             chk;

  fetch_stage_btb #(.btbIdx(btbIdx)) u_btb (
    .clk       (clk),
    .reset     (reset),
    .lk_pc     (pc_q),
    .lk_hit    (hit_F),
    .lk_taken  (predBJ_F),
    .lk_target (btb_target),
    .train_en  (!stall_D && isBJ_D),
    .inval_en  (!stall_D && !isBJ_D && predBJ_D),
    .tr_hit    (hit_D),
    .tr_taken  (realBJ_D),
    .tr_pc     (pc_D),
    .tr_target (targetPC_D)
  );

  // Next-PC selection: a redirect from decode beats a fetch stall
  always_comb begin
    pred_next    = predBJ_F ? btb_target : pc_q + 32'd4;
    correct_next = realBJ_D ? targetPC_D : pc_D + 32'd4;
    chk          = !stall_D && (isBJ_D || predBJ_D);
    mispredict_F = chk && (pc_q != correct_next);
    if (mispredict_F) begin
      pc_d = correct_next;
    end else if (stall_F) begin
      pc_d = pc_q;
    end else begin
      pc_d = pred_next;
    end
  end

  // Fetch PC register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= resetPC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_F       = pc_q;
  assign imemAddr_F = pc_q;
  assign buffIn_D   = {hit_F, predBJ_F, pc_q, imemData_F};

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage with directed vectors
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall_F, stall_D;
  logic        isBJ_D, realBJ_D, predBJ_D, hit_D;
  logic [31:0] imemData_F, pc_D, targetPC_D, imemAddr_F, pc_F;
  logic        mispredict_F;
  logic [65:0] buffIn_D;

  typedef struct {
    logic [31:0] pc;
    logic        hit;
    logic        pred;
    logic        misp;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  assign imemData_F = imemAddr_F ^ 32'hC0DE_0000;

  fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .stall_F      (stall_F),
    .stall_D      (stall_D),
    .imemData_F   (imemData_F),
    .isBJ_D       (isBJ_D),
    .realBJ_D     (realBJ_D),
    .predBJ_D     (predBJ_D),
    .hit_D        (hit_D),
    .pc_D         (pc_D),
    .targetPC_D   (targetPC_D),
    .imemAddr_F   (imemAddr_F),
    .pc_F         (pc_F),
    .mispredict_F (mispredict_F),
    .buffIn_D     (buffIn_D)
  );

  // Monitor: one expected record per cycle, compared mid-cycle
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      logic [65:0] eb;
      e  = sb.pop_front();
      eb = {e.hit, e.pred, e.pc, e.pc ^ 32'hC0DE_0000};
      if (pc_F !== e.pc) begin
        n_bad++;
        $display("FAIL pc_F vec %0d: got %h want %h", n_vec, pc_F, e.pc);
      end
      if (imemAddr_F !== e.pc) begin
        n_bad++;
        $display("FAIL imemAddr_F vec %0d: got %h want %h", n_vec, imemAddr_F, e.pc);
      end
      if (mispredict_F !== e.misp) begin
        n_bad++;
        $display("FAIL mispredict_F vec %0d: got %b want %b", n_vec, mispredict_F, e.misp);
      end
      if (buffIn_D !== eb) begin
        n_bad++;
        $display("FAIL buffIn_D vec %0d: got %h want %h", n_vec, buffIn_D, eb);
      end
      n_vec++;
    end
  end

  // d = {isBJ_D, realBJ_D, predBJ_D, hit_D}
  task automatic cyc(input logic r, input logic sf, input logic sd, input logic [3:0] d,
                     input logic [31:0] pd, input logic [31:0] tg,
                     input logic [31:0] ep, input logic eh, input logic epb, input logic em);
    @(posedge clk);
    #1;
    reset   = r;
    stall_F = sf;
    stall_D = sd;
    {isBJ_D, realBJ_D, predBJ_D, hit_D} = d;
    pc_D       = pd;
    targetPC_D = tg;
    sb.push_back('{pc: ep, hit: eh, pred: epb, misp: em});
  endtask

  task automatic seq(input logic [31:0] ep, input logic eh, input logic epb);
    cyc(1'b1, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, ep, eh, epb, 1'b0);
  endtask

  // Stale-prediction entry in decode: redirects fetch to pd+4
  task automatic rd(input logic [31:0] pd, input logic [31:0] ep, input logic eh, input logic epb);
    cyc(1'b1, 1'b0, 1'b0, 4'b0010, pd, 32'h0, ep, eh, epb, 1'b1);
  endtask

  initial begin
    reset = 1'b0; stall_F = 1'b0; stall_D = 1'b0;
    isBJ_D = 1'b0; realBJ_D = 1'b0; predBJ_D = 1'b0; hit_D = 1'b0;
    pc_D = 32'h0; targetPC_D = 32'h0;

    // reset, sequential fetch, fetch stall
    cyc(1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h00, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h00, 1'b0, 1'b0, 1'b0);
    seq(32'h00, 1'b0, 1'b0);
    seq(32'h04, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h08, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h08, 1'b0, 1'b0, 1'b0);
    seq(32'h08, 1'b0, 1'b0);
    seq(32'h0C, 1'b0, 1'b0);
    seq(32'h10, 1'b0, 1'b0);

    // cold taken branch at 0x10 -> 0x40
    cyc(1'b1, 1'b0, 1'b0, 4'b1100, 32'h10, 32'h40, 32'h14, 1'b0, 1'b0, 1'b1);
    seq(32'h40, 1'b0, 1'b0);
    rd(32'h0C, 32'h44, 1'b0, 1'b0);
    seq(32'h10, 1'b1, 1'b1);

    // hysteresis: taken, taken, not taken, not taken
    cyc(1'b1, 1'b0, 1'b0, 4'b1111, 32'h10, 32'h40, 32'h40, 1'b0, 1'b0, 1'b0);
    rd(32'h0C, 32'h44, 1'b0, 1'b0);
    seq(32'h10, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 4'b1111, 32'h10, 32'h40, 32'h40, 1'b0, 1'b0, 1'b0);
    rd(32'h0C, 32'h44, 1'b0, 1'b0);
    seq(32'h10, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 4'b1011, 32'h10, 32'h40, 32'h40, 1'b0, 1'b0, 1'b1);
    seq(32'h14, 1'b0, 1'b0);
    rd(32'h0C, 32'h18, 1'b0, 1'b0);
    seq(32'h10, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 4'b1011, 32'h10, 32'h40, 32'h40, 1'b0, 1'b0, 1'b1);
    rd(32'h0C, 32'h14, 1'b0, 1'b0);
    seq(32'h10, 1'b1, 1'b0);

    // conflict eviction by 0x50 (index 4, tag 1)
    cyc(1'b1, 1'b0, 1'b0, 4'b1100, 32'h50, 32'h80, 32'h14, 1'b0, 1'b0, 1'b1);
    rd(32'h0C, 32'h80, 1'b0, 1'b0);
    seq(32'h10, 1'b0, 1'b0);

    // stalled decode holding a mispredicted branch
    rd(32'h4C, 32'h14, 1'b0, 1'b0);
    seq(32'h50, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 4'b1011, 32'h50, 32'h80, 32'h80, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 4'b1011, 32'h50, 32'h80, 32'h80, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 4'b1011, 32'h50, 32'h80, 32'h80, 1'b0, 1'b0, 1'b1);
    seq(32'h54, 1'b0, 1'b0);
    rd(32'h4C, 32'h58, 1'b0, 1'b0);
    seq(32'h50, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 4'b1101, 32'h50, 32'h80, 32'h54, 1'b0, 1'b0, 1'b1);
    rd(32'h4C, 32'h80, 1'b0, 1'b0);
    seq(32'h50, 1'b1, 1'b1);

    // asynchronous reset between edges
    cyc(1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h00, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h00, 1'b0, 1'b0, 1'b0);
    rd(32'h0C, 32'h04, 1'b0, 1'b0);
    seq(32'h10, 1'b0, 1'b0);
    seq(32'h14, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d records left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
